// File: rtl/xor_unit_arbiter.sv
// Two-port arbiter in front of one shared 32-bit XOR datapath, with a fixed LATENCY-cycle execute window.
// Tie-break: define ROUND_ROBIN_EN for alternating grants; leave it undefined for fixed priority to port 0.

module xor_gate_32_bit (
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [31:0] o_y
);
   assign o_y = i_a ^ i_b;
endmodule

module xor_unit_arbiter #(
   parameter int LATENCY = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req0_valid,
   input  logic [31:0] i_req0_a,
   input  logic [31:0] i_req0_b,
   output logic        o_req0_ready,
   input  logic        i_req1_valid,
   input  logic [31:0] i_req1_a,
   input  logic [31:0] i_req1_b,
   output logic        o_req1_ready,
   output logic        o_rsp_valid,
   output logic        o_rsp_id,
   output logic [31:0] o_rsp_data,
   input  logic        i_rsp_ready,
   output logic        o_busy
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [3:0]  r_cnt;
   logic [31:0] r_op_a;
   logic [31:0] r_op_b;
   logic        r_op_id;
   logic        r_last_grant;
   logic        r_rsp_valid;
   logic        r_rsp_id;
   logic [31:0] r_rsp_data;
   logic [31:0] w_xor;
   logic        w_prio0;
   logic        w_grant0;
   logic        w_grant1;
   logic        w_req0_ready;
   logic        w_req1_ready;

`ifdef ROUND_ROBIN_EN
   // r_last_grant==1 means port 1 was served last, so port 0 wins the tie.
   assign w_prio0 = r_last_grant;
`else
   logic w_unused_last_grant;
   assign w_prio0             = 1'b1;
   assign w_unused_last_grant = r_last_grant;
`endif

   // Grants are suppressed while reset is asserted so no requester sees ready during rst.
   assign w_grant0 = ~i_rst & i_req0_valid & (~i_req1_valid | w_prio0);
   assign w_grant1 = ~i_rst & i_req1_valid & ~w_grant0;

   xor_gate_32_bit u_xor (
      .i_a (r_op_a),
      .i_b (r_op_b),
      .o_y (w_xor)
   );

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_req0_ready = 1'b0;
      w_req1_ready = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_req0_ready = w_grant0;
            w_req1_ready = w_grant1;
            if (w_grant0 | w_grant1) w_next_state = S_EXEC;
         end
         S_EXEC:  if (r_cnt == 4'd0) w_next_state = S_RESP;
         S_RESP:  if (i_rsp_ready)   w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= 4'd0;
         r_op_a       <= 32'd0;
         r_op_b       <= 32'd0;
         r_op_id      <= 1'b0;
         r_last_grant <= 1'b1;
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= 1'b0;
         r_rsp_data   <= 32'd0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            S_IDLE: begin
               if (w_grant0 | w_grant1) begin
                  r_op_a       <= w_grant1 ? i_req1_a : i_req0_a;
                  r_op_b       <= w_grant1 ? i_req1_b : i_req0_b;
                  r_op_id      <= w_grant1;
                  r_last_grant <= w_grant1;
                  r_cnt        <= 4'(LATENCY - 1);
               end
            end
            S_EXEC: begin
               if (r_cnt == 4'd0) begin
                  r_rsp_data  <= w_xor;
                  r_rsp_id    <= r_op_id;
                  r_rsp_valid <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_RESP: begin
               if (i_rsp_ready) r_rsp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign o_req0_ready = w_req0_ready;
   assign o_req1_ready = w_req1_ready;
   assign o_rsp_valid  = r_rsp_valid;
   assign o_rsp_id     = r_rsp_id;
   assign o_rsp_data   = r_rsp_data;
   assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_xor_unit_arbiter.sv
// Directed bench for xor_unit_arbiter: three instances (LATENCY 1, 4, 15) share one stimulus bus.
// Tie-order expectations follow ROUND_ROBIN_EN when the bench is built with it.

module tb_xor_unit_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        v0 = 1'b0, v1 = 1'b0, rsp_ready = 1'b0;
   logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;

   logic [2:0]  ready0, ready1, rsp_valid, rsp_id, busy;
   logic [31:0] rsp_data [3];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      xor_unit_arbiter #(.LATENCY(g == 0 ? 1 : (g == 1 ? 4 : 15))) u_dut (
         .i_clk        (clk),
         .i_rst        (rst),
         .i_req0_valid (v0),
         .i_req0_a     (a0),
         .i_req0_b     (b0),
         .o_req0_ready (ready0[g]),
         .i_req1_valid (v1),
         .i_req1_a     (a1),
         .i_req1_b     (b1),
         .o_req1_ready (ready1[g]),
         .o_rsp_valid  (rsp_valid[g]),
         .o_rsp_id     (rsp_id[g]),
         .o_rsp_data   (rsp_data[g]),
         .i_rsp_ready  (rsp_ready),
         .o_busy       (busy[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      else             n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Counts edges until rsp_valid of instance idx rises, bounded by budget.
   task automatic wait_valid(input int idx, input int budget, output int cycles);
      cycles = 0;
      do begin
         tick();
         cycles++;
      end while (!rsp_valid[idx] && cycles < budget);
      check("rsp_valid_rises", 32'(rsp_valid[idx]), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int   cyc;
      logic exp_id;
      logic saw_valid;

      // Reset with both valids high
      v0 = 1'b1; v1 = 1'b1;
      do_reset();
      rst = 1'b1;
      tick();
      for (int g = 0; g < 3; g++) begin
         check("ready0_in_rst", 32'(ready0[g]), 32'd0);
         check("ready1_in_rst", 32'(ready1[g]), 32'd0);
      end
      rst = 1'b0;
      #1;
      check("ready0_after_rst", 32'(ready0[0]), 32'd1);
      check("ready1_after_rst", 32'(ready1[0]), 32'd0);
      check("rsp_valid_after_rst", 32'(rsp_valid[0]), 32'd0);
      check("busy_after_rst", 32'(busy[0]), 32'd0);
      check("rsp_data_after_rst", rsp_data[2], 32'd0);

      // Single op on LATENCY=1
      v1 = 1'b0; a0 = 32'hFFFF0000; b0 = 32'h0F0F0F0F; rsp_ready = 1'b1;
      tick();
      v0 = 1'b0;
      #1;
      check("exec_busy", 32'(busy[0]), 32'd1);
      check("exec_no_valid", 32'(rsp_valid[0]), 32'd0);
      check("exec_ready0", 32'(ready0[0]), 32'd0);
      tick();
      check("l1_valid", 32'(rsp_valid[0]), 32'd1);
      check("l1_data", rsp_data[0], 32'hF0F00F0F);
      check("l1_id", 32'(rsp_id[0]), 32'd0);
      tick();
      check("l1_valid_drop", 32'(rsp_valid[0]), 32'd0);
      check("l1_idle", 32'(busy[0]), 32'd0);
      check("l1_data_held", rsp_data[0], 32'hF0F00F0F);

      // Continuous tie: grant order and throughput
      v0 = 1'b1; v1 = 1'b1;
      a0 = 32'h0000_0001; b0 = 32'h0000_0000;
      a1 = 32'h0000_0003; b1 = 32'h0000_0001;
      rsp_ready = 1'b1;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         wait_valid(0, 20, cyc);
`ifdef ROUND_ROBIN_EN
         exp_id = (k % 2) == 1;
`else
         exp_id = 1'b0;
`endif
         check($sformatf("tie_id_%0d", k), 32'(rsp_id[0]), 32'(exp_id));
         check($sformatf("tie_data_%0d", k), rsp_data[0], exp_id ? 32'h2 : 32'h1);
         if (k > 0) check($sformatf("tie_spacing_%0d", k), 32'(cyc), 32'd3);
      end

      // Response backpressure
      v0 = 1'b1; v1 = 1'b1;
      a0 = 32'h13579BDF; b0 = 32'hFFFFFFFF;
      rsp_ready = 1'b0;
      do_reset();
      wait_valid(0, 20, cyc);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("hold_valid", 32'(rsp_valid[0]), 32'd1);
         check("hold_data", rsp_data[0], 32'hECA86420);
         check("hold_id", 32'(rsp_id[0]), 32'd0);
         check("hold_ready0", 32'(ready0[0]), 32'd0);
         check("hold_ready1", 32'(ready1[0]), 32'd0);
         check("hold_busy", 32'(busy[0]), 32'd1);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      #1;
      check("release_valid", 32'(rsp_valid[0]), 32'd0);
      check("release_idle", 32'(busy[0]), 32'd0);
      check("release_data_kept", rsp_data[0], 32'hECA86420);
`ifdef ROUND_ROBIN_EN
      check("release_ready0", 32'(ready0[0]), 32'd0);
      check("release_ready1", 32'(ready1[0]), 32'd1);
`else
      check("release_ready0", 32'(ready0[0]), 32'd1);
      check("release_ready1", 32'(ready1[0]), 32'd0);
`endif
      tick();
      check("next_accept_busy", 32'(busy[0]), 32'd1);

      // Reset during EXEC on LATENCY=4
      v0 = 1'b1; v1 = 1'b0;
      a0 = 32'hAAAAAAAA; b0 = 32'h55555555;
      rsp_ready = 1'b1;
      do_reset();
      tick();
      v0 = 1'b0;
      #1;
      check("l4_exec_busy", 32'(busy[1]), 32'd1);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      saw_valid = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (rsp_valid[1]) saw_valid = 1'b1;
      end
      check("l4_no_rsp", 32'(saw_valid), 32'd0);
      check("l4_idle", 32'(busy[1]), 32'd0);
      check("l4_data_zero", rsp_data[1], 32'd0);

      // LATENCY=15, requester 1
      v0 = 1'b0; v1 = 1'b1;
      a1 = 32'h12345678; b1 = 32'h12345678;
      rsp_ready = 1'b1;
      do_reset();
      #1;
      check("l15_ready1", 32'(ready1[2]), 32'd1);
      tick();
      v1 = 1'b0;
      wait_valid(2, 40, cyc);
      check("l15_latency", 32'(cyc), 32'd15);
      check("l15_data", rsp_data[2], 32'h00000000);
      check("l15_id", 32'(rsp_id[2]), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
